// File: rtl/mem_access_unit.sv
// Memory-side datapath: MAR/MDR/IR registers, internal synchronous RAM and a
// request/busy/done sequencer with configurable wait states before the RAM access.
module mem_access_unit #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned WAIT_STATES  = 1,
    parameter int unsigned OPCODE_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   busC,
    input  logic [DATA_WIDTH-1:0]   bus_alu,
    input  logic                    mar_sclr,
    input  logic                    mar_en,
    input  logic                    mar_inc,
    input  logic                    mdr_en,
    input  logic                    mdr_alu_n,
    input  logic                    ir_sclr,
    input  logic                    ir_en,
    input  logic                    mem_req,
    input  logic                    wr_rdn,
    output logic                    mem_busy,
    output logic                    mem_done,
    output logic                    addr_err,
    output logic [ADDR_WIDTH-1:0]   MAR_m,
    output logic [DATA_WIDTH-1:0]   MDR_m,
    output logic [OPCODE_WIDTH-1:0] instruction
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        wait_cnt, wait_cnt_nxt;
    logic [ADDR_WIDTH-1:0]   cap_addr;
    logic [DATA_WIDTH-1:0]   cap_data;
    logic                    cap_wr;
    logic                    cap_err;
    logic [DATA_WIDTH-1:0]   ram [DEPTH];

    // Next-state logic: IDLE -> WAIT (x WAIT_STATES) -> ACCESS -> DONE -> IDLE
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_IDLE: begin
                wait_cnt_nxt = '0;
                if (mem_req) begin
                    state_nxt = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt == CNT_W'(WAIT_STATES - 1)) begin
                    state_nxt = S_ACCESS;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            S_ACCESS: state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            mem_busy    <= 1'b0;
            mem_done    <= 1'b0;
            addr_err    <= 1'b0;
            MAR_m       <= '0;
            MDR_m       <= '0;
            instruction <= '0;
            cap_addr    <= '0;
            cap_data    <= '0;
            cap_wr      <= 1'b0;
            cap_err     <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            mem_busy <= (state_nxt != S_IDLE);
            mem_done <= (state_nxt == S_DONE);
            addr_err <= (state_nxt == S_DONE) && cap_err;

            // Register-bank side loads are only honoured while the sequencer is idle
            if (state == S_IDLE) begin
                if (mem_req) begin
                    cap_addr <= MAR_m;
                    cap_data <= MDR_m;
                    cap_wr   <= wr_rdn;
                    cap_err  <= (32'(MAR_m) >= DEPTH);
                end
                if (mar_sclr) begin
                    MAR_m <= '0;
                end else if (mar_en) begin
                    MAR_m <= busC[ADDR_WIDTH-1:0];
                end else if (mar_inc) begin
                    MAR_m <= MAR_m + ADDR_WIDTH'(1);
                end
                if (mdr_en && !mdr_alu_n) begin
                    MDR_m <= bus_alu;
                end
            end

            if (state == S_ACCESS && !cap_wr) begin
                MDR_m <= cap_err ? '0 : ram[cap_addr];
            end

            if (ir_sclr) begin
                instruction <= '0;
            end else if (ir_en) begin
                instruction <= MDR_m[DATA_WIDTH-1 -: OPCODE_WIDTH];
            end
        end
    end

    // RAM contents survive reset, but an asserted reset cancels an in-flight write
    always_ff @(posedge clk) begin
        if (rst && state == S_ACCESS && cap_wr && !cap_err) begin
            ram[cap_addr] <= cap_data;
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised memory-side datapath for the processor: MAR, MDR, IR and an internal synchronous RAM.
- A multi-cycle request/busy/done handshake with a configurable number of wait states.
- Sits between the register bank/ALU buses (busC, bus_alu) and the control unit, which issues mem_req and the register enables.
- Adds MAR auto-increment, address-range checking and wait-state sequencing to the existing MAR/MDR/IR path.

Parameters:
- DATA_WIDTH, 8, width of busC, bus_alu, MDR and RAM words.
- ADDR_WIDTH, 8, width of MAR; must be <= DATA_WIDTH.
- DEPTH, 256, number of RAM words; must be <= 2^ADDR_WIDTH.
- WAIT_STATES, 1, extra cycles inserted before the RAM access; 0..15.
- OPCODE_WIDTH, 5, width of IR/instruction; must be <= DATA_WIDTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- busC  in  DATA_WIDTH  register-bank write bus; MAR load source.
- bus_alu  in  DATA_WIDTH  ALU result bus; MDR load source.
- mar_sclr  in  1  synchronous clear of MAR.
- mar_en  in  1  load MAR from busC[ADDR_WIDTH-1:0].
- mar_inc  in  1  MAR <= MAR+1.
- mdr_en  in  1  MDR load enable.
- mdr_alu_n  in  1  MDR source select: 0 = bus_alu, 1 = memory (manual load ignored).
- ir_sclr  in  1  synchronous clear of IR.
- ir_en  in  1  IR <= MDR[DATA_WIDTH-1 -: OPCODE_WIDTH].
- mem_req  in  1  start transaction; sampled only in IDLE.
- wr_rdn  in  1  transaction type, sampled with mem_req: 1 = write MDR to RAM, 0 = read RAM to MDR.
- mem_busy  out  1  high in every non-IDLE state.
- mem_done  out  1  one-cycle pulse in DONE.
- addr_err  out  1  high with mem_done when the captured address >= DEPTH.
- MAR_m  out  ADDR_WIDTH  MAR monitor.
- MDR_m  out  DATA_WIDTH  MDR monitor.
- instruction  out  OPCODE_WIDTH  IR contents.

Behaviour:
Reset:
- rst=0 at a rising edge clears MAR, MDR and IR, sets state IDLE, and drives mem_busy/mem_done/addr_err to 0.
- RAM contents are not reset.
- Reset has priority over every other action, including a pending RAM write.

MAR (IDLE only; ignored while busy):
- Priority mar_sclr > mar_en > mar_inc.
- mar_inc wraps 2^ADDR_WIDTH-1 -> 0.

MDR:
- In IDLE, mdr_en=1 with mdr_alu_n=0 loads bus_alu.
- mdr_en with mdr_alu_n=1 outside a transaction has no effect.
- While busy, only the FSM writes MDR.

IR:
- Updated in any state.
- ir_sclr > ir_en.
- IR takes the top OPCODE_WIDTH bits of the registered MDR, i.e. the pre-edge value.

FSM states:
- IDLE -> (mem_req) -> WAIT, or ACCESS when WAIT_STATES=0.
- WAIT counts WAIT_STATES cycles -> ACCESS.
- ACCESS -> DONE.
- DONE -> IDLE.

Transaction:
- At the accepting edge, capture address = current MAR (pre-edge value), wr_rdn, and write data = current MDR.
- ACCESS edge, write: RAM[addr] <= data.
- ACCESS edge, read: MDR <= RAM[addr].
- Out-of-range address: write suppressed; read loads 0; addr_err=1 in DONE.

Latency:
- mem_req sampled at edge k gives mem_done=1 for the cycle after edge k+WAIT_STATES+1.
- Read data is on MDR_m in that same cycle.
- Total occupancy is WAIT_STATES+2 busy cycles.

Boundary conditions:
- mem_req while busy: ignored and not queued.
- mem_req in the DONE cycle: ignored.
- mem_req together with mar_en/mar_inc in IDLE: transaction uses the old MAR; MAR still updates.
- mem_req together with mdr_en (ALU) in IDLE on a write: RAM receives the old MDR; MDR takes bus_alu.
- Reset during WAIT/ACCESS aborts the transaction; no RAM write occurs, and the next cycle is IDLE with all outputs 0.
- ir_en during a read's ACCESS edge captures the pre-read MDR.

Test Plan:
- Reset: drive rst=0 for 1 edge after arbitrary loads -> MAR_m=0, MDR_m=0, instruction=0, mem_busy=0, mem_done=0.
- Write then read, WAIT_STATES=1:
  - Setup: MAR<=busC=8'h10; MDR<=bus_alu=8'hA5.
  - Write: mem_req, wr_rdn=1 -> mem_busy high 3 cycles, mem_done pulse on the 3rd.
  - Read: clear MDR via bus_alu=0, then mem_req, wr_rdn=0 -> MDR_m=8'hA5 in the done cycle.
- IR load: MDR=8'b10110_011, ir_en=1 -> instruction=5'b10110; ir_sclr=1 together with ir_en -> instruction=0.
- MAR increment and wrap: MAR=8'hFE, mar_inc for 3 cycles -> FF, 00, 01; a mar_en pulse while busy leaves MAR unchanged.
- Out of range: DEPTH=200, MAR=8'hC8, write 8'h3C -> addr_err=1 with mem_done; reading the same address returns MDR=0 with addr_err=1.
- Abort: start a write of 8'h77 to 8'h20, assert rst=0 on the ACCESS edge -> IDLE next cycle; after reset, a read of 8'h20 returns the prior contents, not 8'h77. A second mem_req while busy produces no additional mem_done.
